game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter C_LIVES_INI, default 3: lives loaded at game start (1..3).
REQ-002 Parameter C_MAX_LEVEL, default 9: level at which a level-up ends the game as WIN (1..15).
REQ-003 Parameter C_HIT_CYCLES, default 25000000: freeze duration after a collision.
REQ-004 Parameter C_BANNER_CYCLES, default 50000000: pause duration after a level-up, and before the return from GAME_OVER/WIN to IDLE.
REQ-005 Port i_Clk, input, 1: system clock. One clock only; no other clock domains.
REQ-006 Port i_Rst_L, input, 1: asynchronous active-low reset.
REQ-007 Port i_Start, input, 1: start switch, level-sensitive, already synchronised.
REQ-008 Port i_Has_Collided, input, 1: frog/car collision flag.
REQ-009 Port i_Level_Up, input, 1: one-cycle pulse from the frog controller when the frog reaches the top.
REQ-010 Port o_Game_Active, output, 1: enables frog movement and car motion.
REQ-011 Port o_Frog_Hidden, output, 1: blanks the frog sprite.
REQ-012 Port o_Lives, output, 2: remaining lives.
REQ-013 Port o_Level, output, 4: current level, starting at 1.
REQ-014 Port o_Car_Speed, output, 3: car speed select, equal to min(o_Level-1, 7).
REQ-015 Port o_State, output, 3: state encoding, exported for the HUD.

Function
REQ-016 FSM states and o_State encodings shall be: IDLE=0, PLAYING=1, HIT=2, LEVEL_PAUSE=3, GAME_OVER=4, WIN=5.
REQ-017 Start shall be detected as a rising edge of i_Start, using a registered previous value; a held i_Start shall count as one press only.
REQ-018 IDLE + start edge -> PLAYING on the next cycle; lives=C_LIVES_INI, level=1, timer=0.
REQ-019 PLAYING + i_Has_Collided: the FSM shall go to HIT and decrement lives; if lives were 1 it shall go to GAME_OVER instead, with lives=0.
REQ-020 PLAYING + i_Level_Up: if level==C_MAX_LEVEL, go to WIN with level held; otherwise increment level and go to LEVEL_PAUSE.
REQ-021 Collision and level-up in the same cycle: collision shall win and i_Level_Up shall be ignored.
REQ-022 HIT shall last exactly C_HIT_CYCLES cycles, then return to PLAYING. Collisions during HIT shall be ignored (invulnerability).
REQ-023 LEVEL_PAUSE shall last exactly C_BANNER_CYCLES cycles, then return to PLAYING. All inputs shall be ignored during it.
REQ-024 GAME_OVER and WIN shall wait C_BANNER_CYCLES cycles, then accept a start edge to go to IDLE. Start edges before the timer expires shall be ignored.
REQ-025 A single 32-bit timer shall be cleared on every state entry and increment while below its limit. The transition shall fire on the cycle the timer equals limit-1.
REQ-026 o_Game_Active shall be 1 only in PLAYING; it is a registered output and updates on the cycle the state changes.
REQ-027 o_Frog_Hidden shall be 1 in IDLE, GAME_OVER and WIN. In HIT it shall toggle every 2^22 cycles (timer bit 22) to blink the frog.
REQ-028 o_Lives shall never underflow. o_Level shall saturate at C_MAX_LEVEL. o_Car_Speed is combinational from o_Level with 3-bit saturation.
REQ-029 All outputs except o_Car_Speed shall be registered; latency from an input event to an output change is 1 cycle.

Reset
REQ-030 When i_Rst_L=0, asynchronously: state=IDLE, timer=0, lives=C_LIVES_INI, level=1, previous-start register=1 (so a switch held through reset does not start a game), o_Game_Active=0, o_Frog_Hidden=1.
REQ-031 Reset asserted mid-HIT or mid-pause shall abandon the timer with no residual pulse. Operation resumes on the first clock edge after release.

Structure
REQ-032 The state encodings, C_LIVES_INI and C_MAX_LEVEL shall live in the shared game constants package, also used by the HUD/score renderer.
REQ-033 One sub-module, phase_timer (a parameterisable cycle counter with clear and a done flag), shall be instantiated once inside the sequencer. The FSM shall be a single always block.

Verification (C_HIT_CYCLES=8, C_BANNER_CYCLES=4, C_LIVES_INI=3, C_MAX_LEVEL=2)
REQ-034 Reset then i_Start held high -> stays IDLE. Release and re-press -> o_State=1 and o_Game_Active=1 one cycle after the edge.
REQ-035 Three collisions, each after HIT expires -> lives 3->2->1->0. The third collision gives o_State=4. Each HIT lasts exactly 8 cycles with o_Game_Active=0.
REQ-036 Collision repeated every cycle during HIT -> lives decrement exactly once.
REQ-037 i_Level_Up pulse -> level=2, o_Car_Speed=1, LEVEL_PAUSE for 4 cycles. A second pulse -> o_State=5 and level stays 2.
REQ-038 i_Level_Up and i_Has_Collided in the same cycle -> HIT, lives-1, level unchanged.
REQ-039 i_Rst_L pulsed low mid-HIT -> immediate IDLE, lives=3, level=1, o_Frog_Hidden=1 with no clock edge needed.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared game constants: FSM state encodings, start-of-game defaults and the
// car speed mapping. Also used by the HUD/score renderer.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PLAYING     = 3'd1,
        ST_HIT         = 3'd2,
        ST_LEVEL_PAUSE = 3'd3,
        ST_GAME_OVER   = 3'd4,
        ST_WIN         = 3'd5
    } state_t;

    localparam int unsigned C_LIVES_INI = 3;
    localparam int unsigned C_MAX_LEVEL = 9;

    localparam int TIMER_W   = 32;
    localparam int BLINK_BIT = 22;

    // Car speed select: level-1, saturated to the 3-bit range.
    function automatic logic [2:0] car_speed(input logic [3:0] level);
        if (level == 4'd0)
            return 3'd0;
        else if (level > 4'd8)
            return 3'd7;
        else
            return 3'(level - 4'd1);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and the rest of the game:
// player/frog events in, game mode and HUD values out.
interface game_sequencer_if;
    logic       i_Start;
    logic       i_Has_Collided;
    logic       i_Level_Up;
    logic       o_Game_Active;
    logic       o_Frog_Hidden;
    logic [1:0] o_Lives;
    logic [3:0] o_Level;
    logic [2:0] o_Car_Speed;
    logic [2:0] o_State;

    // Driver side (frog controller / switches / HUD).
    modport master (
        output i_Start, i_Has_Collided, i_Level_Up,
        input  o_Game_Active, o_Frog_Hidden, o_Lives, o_Level, o_Car_Speed, o_State
    );

    // Sequencer side.
    modport slave (
        input  i_Start, i_Has_Collided, i_Level_Up,
        output o_Game_Active, o_Frog_Hidden, o_Lives, o_Level, o_Car_Speed, o_State
    );
endinterface

// File: rtl/game_sequencer_phase_timer.sv
// Phase timer: counts cycles since the last clear, saturating at the limit.
// A clear request is registered by the owner on the state transition edge, so
// the visible count reads zero in the first cycle of the new phase without
// needing the owner's next-state logic.
module phase_timer #(
    parameter int W         = 32,
    parameter int BLINK_BIT = 22
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         done,
    output logic         expired,
    output logic         blink
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] count;

    assign count   = clear ? '0 : cnt_q;
    assign done    = (count == limit - W'(1));
    assign expired = (count >= limit - W'(1));
    assign blink   = count[BLINK_BIT];

    // Count up while below the limit, then hold.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            cnt_q <= '0;
        else if (count < limit)
            cnt_q <= count + W'(1);
        else
            cnt_q <= count;
    end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: top-level game mode FSM (idle / playing / hit freeze /
// level banner / game over / win), lives and level bookkeeping.
module game_sequencer #(
    parameter int unsigned C_LIVES_INI     = game_sequencer_pkg::C_LIVES_INI,
    parameter int unsigned C_MAX_LEVEL     = game_sequencer_pkg::C_MAX_LEVEL,
    parameter int unsigned C_HIT_CYCLES    = 25000000,
    parameter int unsigned C_BANNER_CYCLES = 50000000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    game_sequencer_if.slave   bus
);
    import game_sequencer_pkg::*;

    state_t               state;
    logic [1:0]           lives;
    logic [3:0]           level;
    logic                 start_q;
    logic                 game_active;
    logic                 frog_hidden;
    logic                 tmr_clr;
    logic                 tmr_done;
    logic                 tmr_expired;
    logic                 tmr_blink;
    logic [TIMER_W-1:0]   tmr_limit;
    logic                 start_edge;

    // start_q resets to 1 so a switch held through reset is not a press.
    assign start_edge = bus.i_Start & ~start_q;

    // Only HIT uses the short freeze; every other timed phase uses the banner.
    assign tmr_limit = (state == ST_HIT) ? TIMER_W'(C_HIT_CYCLES)
                                         : TIMER_W'(C_BANNER_CYCLES);

    phase_timer #(
        .W         (TIMER_W),
        .BLINK_BIT (BLINK_BIT)
    ) u_timer (
        .gclk    (i_Clk),
        .grst_n  (i_Rst_L),
        .clear   (tmr_clr),
        .limit   (tmr_limit),
        .done    (tmr_done),
        .expired (tmr_expired),
        .blink   (tmr_blink)
    );

    // Game FSM with its registered outputs; every transition also requests a
    // timer clear so the new phase starts counting from zero.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= ST_IDLE;
            lives       <= 2'(C_LIVES_INI);
            level       <= 4'd1;
            start_q     <= 1'b1;
            game_active <= 1'b0;
            frog_hidden <= 1'b1;
            tmr_clr     <= 1'b0;
        end else begin
            start_q <= bus.i_Start;
            tmr_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state       <= ST_PLAYING;
                        tmr_clr     <= 1'b1;
                        game_active <= 1'b1;
                        frog_hidden <= 1'b0;
                        lives       <= 2'(C_LIVES_INI);
                        level       <= 4'd1;
                    end
                end
                ST_PLAYING: begin
                    // Collision takes priority over a simultaneous level-up.
                    if (bus.i_Has_Collided) begin
                        tmr_clr     <= 1'b1;
                        game_active <= 1'b0;
                        if (lives <= 2'd1) begin
                            state       <= ST_GAME_OVER;
                            lives       <= 2'd0;
                            frog_hidden <= 1'b1;
                        end else begin
                            state       <= ST_HIT;
                            lives       <= lives - 2'd1;
                            frog_hidden <= 1'b0;
                        end
                    end else if (bus.i_Level_Up) begin
                        tmr_clr     <= 1'b1;
                        game_active <= 1'b0;
                        if (level >= 4'(C_MAX_LEVEL)) begin
                            state       <= ST_WIN;
                            frog_hidden <= 1'b1;
                        end else begin
                            state       <= ST_LEVEL_PAUSE;
                            level       <= level + 4'd1;
                            frog_hidden <= 1'b0;
                        end
                    end
                end
                ST_HIT: begin
                    // Invulnerable: collisions are not looked at here.
                    if (tmr_done) begin
                        state       <= ST_PLAYING;
                        tmr_clr     <= 1'b1;
                        game_active <= 1'b1;
                        frog_hidden <= 1'b0;
                    end else begin
                        frog_hidden <= tmr_blink;
                    end
                end
                ST_LEVEL_PAUSE: begin
                    if (tmr_done) begin
                        state       <= ST_PLAYING;
                        tmr_clr     <= 1'b1;
                        game_active <= 1'b1;
                        frog_hidden <= 1'b0;
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    // Banner must run out before a press returns to IDLE.
                    if (tmr_expired && start_edge) begin
                        state       <= ST_IDLE;
                        tmr_clr     <= 1'b1;
                        game_active <= 1'b0;
                        frog_hidden <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    tmr_clr     <= 1'b1;
                    game_active <= 1'b0;
                    frog_hidden <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_State       = state;
    assign bus.o_Game_Active = game_active;
    assign bus.o_Frog_Hidden = frog_hidden;
    assign bus.o_Lives       = lives;
    assign bus.o_Level       = level;
    assign bus.o_Car_Speed   = car_speed(level);

endmodule
